// File: rtl/alu_sweep_engine.sv
// Hack-style ALU fed from two writable operand banks, with a sequencer that runs
// one operand pair or a full A x B sweep and counts zero/negative results per run.
module alu_sweep_engine #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2*ADDR_W+1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic              wr_sel_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic [5:0]        ctrl_i,
  input  logic              start_i,
  input  logic              single_i,
  input  logic [ADDR_W-1:0] addr_a_i,
  input  logic [ADDR_W-1:0] addr_b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              res_valid_o,
  output logic [WIDTH-1:0]  result_o,
  output logic              zr_o,
  output logic              ng_o,
  output logic [ADDR_W-1:0] cur_a_o,
  output logic [ADDR_W-1:0] cur_b_o,
  output logic [CNT_W-1:0]  zr_count_o,
  output logic [CNT_W-1:0]  ng_count_o,
  output logic              wr_err_o,
  output logic [1:0]        state_o
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [WIDTH-1:0]    bank_a_q [DEPTH];
  logic [WIDTH-1:0]    bank_b_q [DEPTH];
  logic [1:0]          state_q, state_d;
  logic [5:0]          ctrl_q, ctrl_d;
  logic                single_q, single_d;
  logic [ADDR_W-1:0]   ia_q, ia_d, ib_q, ib_d;
  logic [2*ADDR_W-1:0] pair_nxt;
  logic                clr_cnt;
  logic [WIDTH-1:0]    alu_out;

  logic                s_vld_q;
  logic [WIDTH-1:0]    s_res_q;
  logic [ADDR_W-1:0]   s_a_q, s_b_q;

  logic                res_valid_q, done_q, zr_q, ng_q, wr_err_q;
  logic [WIDTH-1:0]    result_q;
  logic [ADDR_W-1:0]   cur_a_q, cur_b_q;
  logic [CNT_W-1:0]    zr_cnt_q, ng_cnt_q;

  function automatic logic [WIDTH-1:0] hack_alu(input logic [5:0] c,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] xv, yv, o;
    xv = c[5] ? '0 : x;
    xv = c[4] ? ~xv : xv;
    yv = c[3] ? '0 : y;
    yv = c[2] ? ~yv : yv;
    o  = c[1] ? (xv + yv) : (xv & yv);
    return c[0] ? ~o : o;
  endfunction

  // Banks are not reset; writes only land while IDLE so a run sees stable operands.
  always_ff @(posedge clk) begin
    if (wr_en_i && (state_q == ST_IDLE)) begin
      if (wr_sel_i) bank_b_q[wr_addr_i] <= wr_data_i;
      else          bank_a_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign alu_out  = hack_alu(ctrl_q, bank_a_q[ia_q], bank_b_q[ib_q]);
  assign pair_nxt = {ia_q, ib_q} + {{(2*ADDR_W-1){1'b0}}, 1'b1};

  // Handshake: start_i is a level, accepted on any IDLE edge where it is high;
  // there is no ready, so the caller watches busy_o/done_o to know when it can restart.
  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    single_d = single_q;
    ia_d     = ia_q;
    ib_d     = ib_q;
    clr_cnt  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          ctrl_d   = ctrl_i;
          single_d = single_i;
          clr_cnt  = 1'b1;
          ia_d     = single_i ? addr_a_i : '0;
          ib_d     = single_i ? addr_b_i : '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (single_q || ((ia_q == '1) && (ib_q == '1))) begin
          state_d = ST_DONE;
        end else begin
          {ia_d, ib_d} = pair_nxt;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ctrl_q      <= '0;
      single_q    <= 1'b0;
      ia_q        <= '0;
      ib_q        <= '0;
      s_vld_q     <= 1'b0;
      s_res_q     <= '0;
      s_a_q       <= '0;
      s_b_q       <= '0;
      res_valid_q <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      zr_q        <= 1'b0;
      ng_q        <= 1'b0;
      cur_a_q     <= '0;
      cur_b_q     <= '0;
      zr_cnt_q    <= '0;
      ng_cnt_q    <= '0;
      wr_err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      single_q <= single_d;
      ia_q     <= ia_d;
      ib_q     <= ib_d;
      // One pipeline stage between evaluation and the output register.
      s_vld_q  <= (state_q == ST_RUN);
      if (state_q == ST_RUN) begin
        s_res_q <= alu_out;
        s_a_q   <= ia_q;
        s_b_q   <= ib_q;
      end
      res_valid_q <= s_vld_q;
      done_q      <= (state_q == ST_DONE);
      if (s_vld_q) begin
        result_q <= s_res_q;
        zr_q     <= (s_res_q == '0);
        ng_q     <= s_res_q[WIDTH-1];
        cur_a_q  <= s_a_q;
        cur_b_q  <= s_b_q;
      end
      if (clr_cnt) begin
        zr_cnt_q <= '0;
        ng_cnt_q <= '0;
      end else if (s_vld_q) begin
        if (s_res_q == '0)     zr_cnt_q <= zr_cnt_q + CNT_W'(1);
        if (s_res_q[WIDTH-1])  ng_cnt_q <= ng_cnt_q + CNT_W'(1);
      end
      wr_err_q <= wr_en_i && (state_q != ST_IDLE);
    end
  end

  assign busy_o      = (state_q == ST_RUN);
  assign done_o      = done_q;
  assign res_valid_o = res_valid_q;
  assign result_o    = result_q;
  assign zr_o        = zr_q;
  assign ng_o        = ng_q;
  assign cur_a_o     = cur_a_q;
  assign cur_b_o     = cur_b_q;
  assign zr_count_o  = zr_cnt_q;
  assign ng_count_o  = ng_cnt_q;
  assign wr_err_o    = wr_err_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_alu_sweep_engine.sv
// Bench for alu_sweep_engine: table of Hack ALU ops, directed multi-cycle corner
// cases, and random runs against an arithmetic reference model.
module tb_alu_sweep_engine;
  localparam int WIDTH  = 16;
  localparam int ADDR_W = 2;
  localparam int CNT_W  = 2*ADDR_W+1;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam longint MASK = (64'd1 << WIDTH) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_en = 1'b0, wr_sel = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [WIDTH-1:0]  wr_data = '0;
  logic [5:0]        ctrl = '0;
  logic              start = 1'b0, single = 1'b0;
  logic [ADDR_W-1:0] addr_a = '0, addr_b = '0;
  logic              busy, done, res_valid, zr, ng, wr_err;
  logic [WIDTH-1:0]  result;
  logic [ADDR_W-1:0] cur_a, cur_b;
  logic [CNT_W-1:0]  zr_count, ng_count;
  logic [1:0]        state;

  int checks = 0;
  int failures = 0;
  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [WIDTH+2*ADDR_W-1:0] exp_q[$];

  typedef struct {
    logic [5:0]       c;
    logic [WIDTH-1:0] exp;
  } vec_t;
  vec_t vecs [16];

  alu_sweep_engine #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en_i(wr_en), .wr_sel_i(wr_sel),
    .wr_addr_i(wr_addr), .wr_data_i(wr_data), .ctrl_i(ctrl), .start_i(start),
    .single_i(single), .addr_a_i(addr_a), .addr_b_i(addr_b), .busy_o(busy),
    .done_o(done), .res_valid_o(res_valid), .result_o(result), .zr_o(zr),
    .ng_o(ng), .cur_a_o(cur_a), .cur_b_o(cur_b), .zr_count_o(zr_count),
    .ng_count_o(ng_count), .wr_err_o(wr_err), .state_o(state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [WIDTH-1:0] ref_alu(input logic [5:0] c,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    longint x, y, o;
    x = c[5] ? 0 : longint'(a);
    if (c[4]) x = MASK - x;
    y = c[3] ? 0 : longint'(b);
    if (c[2]) y = MASK - y;
    o = c[1] ? ((x + y) % (MASK + 1)) : (x & y);
    if (c[0]) o = MASK - o;
    return WIDTH'(o);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic write_bank(input logic sel, input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_sel = sel; wr_addr = a; wr_data = d;
    @(posedge clk);
    #1 wr_en = 1'b0;
    if (sel) mem_b[a] = d; else mem_a[a] = d;
  endtask

  task automatic run_single(input string name, input logic [5:0] c,
                            input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                            input logic [WIDTH-1:0] exp,
                            input logic do_wr, input logic w_sel,
                            input logic [ADDR_W-1:0] w_addr, input logic [WIDTH-1:0] w_data);
    @(negedge clk);
    ctrl = c; single = 1'b1; addr_a = a; addr_b = b; start = 1'b1;
    if (do_wr) begin
      wr_en = 1'b1; wr_sel = w_sel; wr_addr = w_addr; wr_data = w_data;
    end
    @(posedge clk);
    #1 start = 1'b0; wr_en = 1'b0;
    if (do_wr) begin
      if (w_sel) mem_b[w_addr] = w_data; else mem_a[w_addr] = w_data;
    end
    @(negedge clk);
    chk({name, "_busy"}, busy, 1);
    chk({name, "_early_valid"}, res_valid, 0);
    ctrl = 6'($urandom_range(0, 63)); addr_a = ~a; addr_b = ~b; single = 1'b0;
    @(negedge clk);
    chk({name, "_early_valid2"}, res_valid, 0);
    @(negedge clk);
    chk({name, "_valid"}, res_valid, 1);
    chk({name, "_done"}, done, 1);
    chk({name, "_result"}, result, exp);
    chk({name, "_zr"}, zr, (exp == '0));
    chk({name, "_ng"}, ng, exp[WIDTH-1]);
    chk({name, "_cur_a"}, cur_a, a);
    chk({name, "_cur_b"}, cur_b, b);
    chk({name, "_zr_count"}, zr_count, (exp == '0) ? 1 : 0);
    chk({name, "_ng_count"}, ng_count, exp[WIDTH-1] ? 1 : 0);
    @(negedge clk);
    chk({name, "_valid_pulse"}, res_valid, 0);
    chk({name, "_done_pulse"}, done, 0);
    chk({name, "_hold"}, result, exp);
  endtask

  task automatic run_sweep(input string name, input logic [5:0] c,
                           input logic inject_wr, input int abort_at);
    int ezr, eng, got, busy_cnt;
    logic finished;
    logic [WIDTH+2*ADDR_W-1:0] e;
    exp_q.delete();
    ezr = 0; eng = 0;
    for (int a = 0; a < DEPTH; a++) begin
      for (int b = 0; b < DEPTH; b++) begin
        logic [WIDTH-1:0] r;
        r = ref_alu(c, mem_a[a], mem_b[b]);
        exp_q.push_back({ADDR_W'(a), ADDR_W'(b), r});
        if (r == '0) ezr++;
        if (r[WIDTH-1]) eng++;
      end
    end
    @(negedge clk);
    ctrl = c; single = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    got = 0; busy_cnt = 0; finished = 1'b0;
    for (int cyc = 0; cyc < DEPTH*DEPTH + 8 && !finished; cyc++) begin
      @(negedge clk);
      if (inject_wr && cyc == 2) begin
        chk({name, "_wr_err_idle"}, wr_err, 0);
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 2; wr_data = 16'hAAAA;
      end
      if (inject_wr && cyc == 3) begin
        chk({name, "_wr_err"}, wr_err, 1);
        wr_en = 1'b0;
      end
      if (busy) busy_cnt++;
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          chk({name, "_extra_result"}, 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk({name, "_result"}, result, e[WIDTH-1:0]);
          chk({name, "_cur_a"}, cur_a, e[WIDTH+2*ADDR_W-1:WIDTH+ADDR_W]);
          chk({name, "_cur_b"}, cur_b, e[WIDTH+ADDR_W-1:WIDTH]);
        end
        got++;
        chk({name, "_done_timing"}, done, (got == DEPTH*DEPTH));
        if (done) finished = 1'b1;
        if (abort_at != 0 && got == abort_at) begin
          rst_n = 1'b0;
          #1;
          chk({name, "_rst_busy"}, busy, 0);
          chk({name, "_rst_done"}, done, 0);
          chk({name, "_rst_valid"}, res_valid, 0);
          chk({name, "_rst_result"}, result, 0);
          chk({name, "_rst_zr_count"}, zr_count, 0);
          chk({name, "_rst_ng_count"}, ng_count, 0);
          chk({name, "_rst_state"}, state, 0);
          exp_q.delete();
          @(negedge clk);
          rst_n = 1'b1;
          return;
        end
      end
    end
    chk({name, "_finished"}, finished, 1);
    chk({name, "_count"}, got, DEPTH*DEPTH);
    chk({name, "_busy_cycles"}, busy_cnt, DEPTH*DEPTH);
    chk({name, "_zr_count"}, zr_count, ezr);
    chk({name, "_ng_count"}, ng_count, eng);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vecs[0]  = '{6'b000010, 16'h0008};  vecs[1]  = '{6'b010011, 16'h0002};
    vecs[2]  = '{6'b000111, 16'hFFFE};  vecs[3]  = '{6'b000000, 16'h0001};
    vecs[4]  = '{6'b010101, 16'h0007};  vecs[5]  = '{6'b101010, 16'h0000};
    vecs[6]  = '{6'b111111, 16'h0001};  vecs[7]  = '{6'b111010, 16'hFFFF};
    vecs[8]  = '{6'b001100, 16'h0005};  vecs[9]  = '{6'b110000, 16'h0003};
    vecs[10] = '{6'b001101, 16'hFFFA};  vecs[11] = '{6'b001111, 16'hFFFB};
    vecs[12] = '{6'b011111, 16'h0006};  vecs[13] = '{6'b110111, 16'h0004};
    vecs[14] = '{6'b001110, 16'h0004};  vecs[15] = '{6'b110010, 16'h0002};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", state, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_valid", res_valid, 0);
    chk("reset_result", result, 0);
    chk("reset_counts", {zr_count, ng_count}, 0);
    chk("reset_flags", {zr, ng, wr_err, cur_a, cur_b}, 0);
    rst_n = 1'b1;

    // Table of ALU functions with x=5, y=3
    write_bank(1'b0, 1, 16'd5);
    write_bank(1'b1, 2, 16'd3);
    for (int i = 0; i < 16; i++) begin
      run_single($sformatf("vec%0d", i), vecs[i].c, 1, 2, vecs[i].exp, 1'b0, 1'b0, '0, '0);
    end

    write_bank(1'b0, 3, 16'd3);
    write_bank(1'b1, 1, 16'd5);
    run_single("single_add", 6'b000010, 3, 1, 16'h0008, 1'b0, 1'b0, '0, '0);
    write_bank(1'b0, 1, 16'd1);
    write_bank(1'b1, 3, 16'd3);
    run_single("single_sub", 6'b010011, 1, 3, 16'hFFFE, 1'b0, 1'b0, '0, '0);
    run_single("minus_one", 6'b111010, 1, 3, 16'hFFFF, 1'b0, 1'b0, '0, '0);

    for (int i = 0; i < DEPTH; i++) begin
      write_bank(1'b0, ADDR_W'(i), WIDTH'(i));
      write_bank(1'b1, ADDR_W'(i), WIDTH'(i));
    end
    run_sweep("and_sweep", 6'b000000, 1'b1, 0);
    chk("and_sweep_zr9", zr_count, 9);
    run_single("rejected_write", 6'b001100, 2, 0, 16'h0002, 1'b0, 1'b0, '0, '0);

    run_sweep("abort_sweep", 6'b000010, 1'b0, 5);
    run_single("post_reset", 6'b000010, 2, 3, 16'h0005, 1'b0, 1'b0, '0, '0);

    write_bank(1'b0, 0, 16'd0);
    run_single("wr_start", 6'b000010, 0, 0, 16'h0007, 1'b1, 1'b1, 0, 16'd7);

    // Random contents, ops and indices
    for (int i = 0; i < DEPTH; i++) begin
      write_bank(1'b0, ADDR_W'(i), WIDTH'($urandom));
      write_bank(1'b1, ADDR_W'(i), WIDTH'($urandom));
    end
    for (int i = 0; i < 12; i++) begin
      logic [5:0] c;
      logic [ADDR_W-1:0] a, b;
      c = 6'($urandom_range(0, 63));
      a = ADDR_W'($urandom_range(0, DEPTH-1));
      b = ADDR_W'($urandom_range(0, DEPTH-1));
      run_single($sformatf("rand%0d", i), c, a, b, ref_alu(c, mem_a[a], mem_b[b]),
                 1'b0, 1'b0, '0, '0);
    end
    run_sweep("rand_sweep", 6'($urandom_range(0, 63)), 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
